// File: rtl/bus_pkg.sv
// Shared definitions for the core/loader memory + GPIO bus: widths, arbiter states,
// and the access-size option codes understood by Core and Memory.
package bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } bus_state_e;

    localparam logic [2:0] OptByte  = 3'b000;
    localparam logic [2:0] OptHalf  = 3'b001;
    localparam logic [2:0] OptWord  = 3'b010;
    localparam logic [2:0] OptByteU = 3'b100;
    localparam logic [2:0] OptHalfU = 3'b101;

endpackage

// File: rtl/arb_rr2.sv
// Two-requester picker: fixed priority to requester 0, or round-robin where the
// requester granted last loses a tie. Combinational; the caller owns the pointer.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       mode,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (mode && !last) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with a single outstanding access and a slave
// watchdog that completes a hung access with an error instead of stalling the master.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned          PRIORITY_MODE  = 0,
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [BUS_DW-1:0]    ERROR_DATA     = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [2:0]        m0_option,
    input  logic [BUS_AW-1:0] m0_address,
    input  logic [BUS_DW-1:0] m0_write_data,
    output logic [BUS_DW-1:0] m0_read_data,
    output logic              m0_response,
    output logic              m0_error,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [2:0]        m1_option,
    input  logic [BUS_AW-1:0] m1_address,
    input  logic [BUS_DW-1:0] m1_write_data,
    output logic [BUS_DW-1:0] m1_read_data,
    output logic              m1_response,
    output logic              m1_error,
    output logic              s_read,
    output logic              s_write,
    output logic [2:0]        s_option,
    output logic [BUS_AW-1:0] s_address,
    output logic [BUS_DW-1:0] s_write_data,
    input  logic [BUS_DW-1:0] s_read_data,
    input  logic              s_response,
    output logic [1:0]        grant
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast =
        CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic RrMode = (PRIORITY_MODE != 0);

    bus_state_e               state_q, state_d;
    logic                     last_q, last_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [1:0]               grant_q, grant_d;
    logic                     s_read_q, s_read_d, s_write_q, s_write_d;
    logic [2:0]               s_option_q, s_option_d;
    logic [BUS_AW-1:0]        s_address_q, s_address_d;
    logic [BUS_DW-1:0]        s_write_data_q, s_write_data_d;
    logic [1:0]               resp_q, resp_d, err_q, err_d;
    logic [1:0][BUS_DW-1:0]   rdata_q, rdata_d;
    logic [1:0]               req, pick;
    logic                     owner, timeout;

    assign req     = {m1_read | m1_write, m0_read | m0_write};
    assign owner   = grant_q[1];
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CntLast);

    arb_rr2 u_pick (
        .req  (req),
        .mode (RrMode),
        .last (last_q),
        .gnt  (pick)
    );

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        s_read_d       = s_read_q;
        s_write_d      = s_write_q;
        s_option_d     = s_option_q;
        s_address_d    = s_address_q;
        s_write_data_d = s_write_data_q;
        resp_d         = '0;
        err_d          = '0;
        rdata_d        = '0;

        case (state_q)
            StIdle: begin
                grant_d = '0;
                if (|req) begin
                    state_d = StBusy;
                    grant_d = pick;
                    last_d  = pick[1];
                    cnt_d   = '0;
                    // Read and write together is treated as a write.
                    if (pick[1]) begin
                        s_write_d      = m1_write;
                        s_read_d       = m1_read & ~m1_write;
                        s_option_d     = m1_option;
                        s_address_d    = m1_address;
                        s_write_data_d = m1_write_data;
                    end else begin
                        s_write_d      = m0_write;
                        s_read_d       = m0_read & ~m0_write;
                        s_option_d     = m0_option;
                        s_address_d    = m0_address;
                        s_write_data_d = m0_write_data;
                    end
                end
            end
            StBusy: begin
                if (s_response || timeout) begin
                    state_d   = StDone;
                    s_read_d  = 1'b0;
                    s_write_d = 1'b0;
                    resp_d    = grant_q;
                    err_d     = s_response ? 2'b00 : grant_q;
                    if (s_read_q) begin
                        rdata_d[owner] = s_response ? s_read_data : ERROR_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = '0;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            last_q         <= 1'b1;
            cnt_q          <= '0;
            grant_q        <= '0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            s_option_q     <= '0;
            s_address_q    <= '0;
            s_write_data_q <= '0;
            resp_q         <= '0;
            err_q          <= '0;
            rdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            s_option_q     <= s_option_d;
            s_address_q    <= s_address_d;
            s_write_data_q <= s_write_data_d;
            resp_q         <= resp_d;
            err_q          <= err_d;
            rdata_q        <= rdata_d;
        end
    end

    assign m0_response  = resp_q[0];
    assign m1_response  = resp_q[1];
    assign m0_error     = err_q[0];
    assign m1_error     = err_q[1];
    assign m0_read_data = rdata_q[0];
    assign m1_read_data = rdata_q[1];
    assign s_read       = s_read_q;
    assign s_write      = s_write_q;
    assign s_option     = s_option_q;
    assign s_address    = s_address_q;
    assign s_write_data = s_write_data_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table of single accesses checked against a response
// scoreboard, plus hand sequences for spurious responses, mid-op reset and tie-breaking.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
    logic [2:0]  m0_option = 0, m1_option = 0;
    logic [31:0] m0_address = 0, m1_address = 0, m0_write_data = 0, m1_write_data = 0;
    logic [31:0] m0_read_data, m1_read_data, s_address, s_write_data;
    logic        m0_response, m1_response, m0_error, m1_error, s_read, s_write;
    logic [2:0]  s_option;
    logic [1:0]  grant;
    logic [31:0] s_read_data = 0;
    logic        s_response = 0;

    // Fixed-priority instance, fed the same master traffic, slave answers at once.
    logic [31:0] f_m0_read_data, f_m1_read_data, f_s_address, f_s_write_data;
    logic        f_m0_response, f_m1_response, f_m0_error, f_m1_error, f_s_read, f_s_write;
    logic [2:0]  f_s_option;
    logic [1:0]  f_grant;
    logic [31:0] f_s_read_data;
    logic        f_s_response;
    assign f_s_read_data = 32'h1111_2222;
    assign f_s_response  = f_s_read | f_s_write;

    int          n_vec = 0, n_bad = 0;
    int          lat_cfg = 0, age = 0;
    logic        spur = 0;
    logic [31:0] slave_data = 0;

    typedef struct {
        logic m; logic rd; logic wr; logic [2:0] opt; logic [31:0] addr; logic [31:0] wdata;
        int lat; logic [31:0] sdata; logic exp_err; logic [31:0] exp_rdata; int exp_cyc;
    } vec_t;
    typedef struct { logic m; logic err; logic [31:0] rdata; } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[9];

    always #5 clk = ~clk;

    bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8), .ERROR_DATA(ERRD)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(m0_read_data), .m0_response(m0_response), .m0_error(m0_error),
        .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(m1_read_data), .m1_response(m1_response), .m1_error(m1_error),
        .s_read(s_read), .s_write(s_write), .s_option(s_option), .s_address(s_address),
        .s_write_data(s_write_data), .s_read_data(s_read_data), .s_response(s_response),
        .grant(grant)
    );

    bus_arbiter #(.PRIORITY_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n),
        .m0_read(m0_read), .m0_write(m0_write), .m0_option(m0_option),
        .m0_address(m0_address), .m0_write_data(m0_write_data),
        .m0_read_data(f_m0_read_data), .m0_response(f_m0_response), .m0_error(f_m0_error),
        .m1_read(m1_read), .m1_write(m1_write), .m1_option(m1_option),
        .m1_address(m1_address), .m1_write_data(m1_write_data),
        .m1_read_data(f_m1_read_data), .m1_response(f_m1_response), .m1_error(f_m1_error),
        .s_read(f_s_read), .s_write(f_s_write), .s_option(f_s_option),
        .s_address(f_s_address), .s_write_data(f_s_write_data),
        .s_read_data(f_s_read_data), .s_response(f_s_response), .grant(f_grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: answers in strobe cycle lat_cfg (1 = same cycle as strobe), never if 0.
    always @(negedge clk) begin
        age         <= (s_read || s_write) ? age + 1 : 0;
        s_response  <= spur | ((lat_cfg != 0) && (s_read || s_write) && (age + 1 == lat_cfg));
        s_read_data <= ((lat_cfg != 0) && (s_read || s_write) && (age + 1 == lat_cfg))
                       ? slave_data : 32'h0BAD_0BAD;
    end

    // Response monitor: every completion pops one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_response || m1_response) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got m1/m0=%0b%0b, want none at %0t",
                             m1_response, m0_response, $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_owner", 32'({m1_response, m0_response}),
                          mon_e.m ? 32'd2 : 32'd1);
                    check("resp_error", 32'(mon_e.m ? m1_error : m0_error), 32'(mon_e.err));
                    check("resp_rdata", mon_e.m ? m1_read_data : m0_read_data, mon_e.rdata);
                    check("other_quiet", mon_e.m ? (m0_read_data | 32'(m0_error))
                                                 : (m1_read_data | 32'(m1_error)), 32'd0);
                end
            end else begin
                check("idle_rdata", m0_read_data | m1_read_data, 32'd0);
                check("idle_error", 32'({m1_error, m0_error}), 32'd0);
            end
        end
    end

    task automatic drive_m(input logic m, input logic rd, input logic wr, input logic [2:0] opt,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (m) begin
            m1_read = rd; m1_write = wr; m1_option = opt; m1_address = addr; m1_write_data = wdata;
        end else begin
            m0_read = rd; m0_write = wr; m0_option = opt; m0_address = addr; m0_write_data = wdata;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lat_cfg = 0;
        spur = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_m(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_strobes", 32'({s_read, s_write}), 32'd0);
        check("rst_s_option", 32'(s_option), 32'd0);
        check("rst_s_address", s_address, 32'd0);
        check("rst_s_wdata", s_write_data, 32'd0);
        check("rst_resp_err", 32'({m1_response, m0_response, m1_error, m0_error}), 32'd0);
        check("rst_rdata", m0_read_data | m1_read_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_access(input vec_t v);
        int   cyc;
        bit   stable;
        exp_t e;
        @(negedge clk);
        lat_cfg = v.lat;
        slave_data = v.sdata;
        drive_m(v.m, v.rd, v.wr, v.opt, v.addr, v.wdata);
        e.m = v.m; e.err = v.exp_err; e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("grant", 32'(grant), v.m ? 32'd2 : 32'd1);
        check("s_read", 32'(s_read), 32'(v.rd & ~v.wr));
        check("s_write", 32'(s_write), 32'(v.wr));
        check("s_option", 32'(s_option), 32'(v.opt));
        check("s_address", s_address, v.addr);
        check("s_write_data", s_write_data, v.wdata);
        // Master changes its bus mid-access; the latched slave side must not follow.
        drive_m(v.m, v.rd, v.wr, ~v.opt, ~v.addr, ~v.wdata);
        cyc = 0;
        stable = 1'b1;
        while ((s_read || s_write) && cyc < 40) begin
            cyc++;
            if (s_address !== v.addr || s_option !== v.opt || s_write_data !== v.wdata ||
                grant !== (v.m ? 2'b10 : 2'b01)) stable = 1'b0;
            @(posedge clk);
            #1;
        end
        check("strobe_cycles", 32'(cyc), 32'(v.exp_cyc));
        check("busy_stable", 32'(stable), 32'd1);
        check("resp_pulse", 32'({m1_response, m0_response}), v.m ? 32'd2 : 32'd1);
        drive_m(v.m, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("idle_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish by 200000");
        $fatal(1, "bench hung");
    end

    initial begin
        vec_t v;
        int   w;
        //           m     rd    wr    opt       addr           wdata          lat sdata
        //           err   rdata          cyc
        vecs[0] = '{1'b0, 1'b1, 1'b0, OptWord,  32'h0000_0010, 32'h0,         2, 32'hCAFE_F00D,
                    1'b0, 32'hCAFE_F00D, 2};
        vecs[1] = '{1'b1, 1'b0, 1'b1, OptWord,  32'h8000_0004, 32'h0000_00A5, 1, 32'h5555_AAAA,
                    1'b0, 32'h0,         1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, OptByte,  32'h0000_0020, 32'h0,         0, 32'h1234_0000,
                    1'b1, ERRD,          8};
        vecs[3] = '{1'b0, 1'b0, 1'b1, OptHalf,  32'h0000_0024, 32'h0000_1234, 3, 32'h3333_3333,
                    1'b0, 32'h0,         3};
        vecs[4] = '{1'b1, 1'b1, 1'b0, OptByteU, 32'h3000_0001, 32'h0,         8, 32'h0000_0077,
                    1'b0, 32'h0000_0077, 8};
        vecs[5] = '{1'b1, 1'b1, 1'b1, OptHalfU, 32'h0000_0044, 32'h0000_BEEF, 1, 32'h4444_4444,
                    1'b0, 32'h0,         1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, OptWord,  32'h0000_0048, 32'h0000_0066, 0, 32'h0,
                    1'b1, 32'h0,         8};
        vecs[7] = '{1'b0, 1'b1, 1'b0, OptWord,  32'h0000_004C, 32'h0,         9, 32'h0000_0099,
                    1'b1, ERRD,          8};
        vecs[8] = '{1'b0, 1'b1, 1'b0, OptWord,  32'h0000_0050, 32'h0,         1, 32'h0F0F_0F0F,
                    1'b0, 32'h0F0F_0F0F, 1};

        do_reset();
        for (int i = 0; i < 9; i++) do_access(vecs[i]);

        // Slave response while idle must be ignored.
        @(negedge clk);
        spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("spur_grant", 32'(grant), 32'd0);
            check("spur_strobes", 32'({s_read, s_write}), 32'd0);
        end
        @(negedge clk);
        spur = 1'b0;

        // Reset in the middle of a hung m1 read: dropped with no response.
        @(negedge clk);
        lat_cfg = 0;
        drive_m(1'b1, 1'b1, 1'b0, OptWord, 32'h0000_0040, 32'h0);
        @(posedge clk);
        #1;
        check("midop_grant", 32'(grant), 32'd2);
        repeat (2) @(posedge clk);
        do_reset();
        v = '{1'b1, 1'b0, 1'b1, OptWord, 32'h0000_0054, 32'h0000_0077, 1, 32'h0,
              1'b0, 32'h0, 1};
        do_access(v);

        // Continuous tie after reset: round-robin alternates starting at m0, fixed stays m0.
        do_reset();
        @(negedge clk);
        lat_cfg = 1;
        slave_data = 32'hA0A0_0001;
        drive_m(1'b0, 1'b1, 1'b0, OptWord, 32'h0000_0100, 32'h0);
        drive_m(1'b1, 1'b0, 1'b1, OptWord, 32'h0000_0200, 32'h0000_5A5A);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.m = (k % 2 == 1);
            e.err = 1'b0;
            e.rdata = e.m ? 32'h0 : 32'hA0A0_0001;
            sb.push_back(e);
        end
        for (int k = 0; k < 4; k++) begin
            w = 0;
            do begin
                @(posedge clk);
                #1;
                w++;
            end while (grant == 2'b00 && w < 10);
            check("rr_grant", 32'(grant), (k % 2 == 1) ? 32'd2 : 32'd1);
            check("fixed_grant", 32'(f_grant), 32'd1);
            w = 0;
            do begin
                @(posedge clk);
                #1;
                w++;
            end while (grant != 2'b00 && w < 10);
            check("rr_release", 32'(grant), 32'd0);
        end
        drive_m(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive_m(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 32'(grant), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
